fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined MIPS core. It owns the program counter, issues instruction-memory requests, and buffers fetched words with their PC+4 in a DEPTH-entry FIFO ahead of the IF/ID stage. Decode can therefore stall without blocking fetch. The block adds three behaviours to the existing single-register PC logic: redirect-with-flush, HALT-opcode fetch stop, and a sticky halt.

---
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue port bundle: instruction-memory request side, decode side,
// redirect/halt control and status. master = fetch_queue, slave = environment.
interface fetch_queue_if #(
  parameter int CNT_W = 3
);
  // Handshake rules: a fetch is accepted on a cycle with imemREN && ihit;
  // decode consumes the head on a cycle with valid_out && deq. ihit without
  // imemREN and deq without valid_out are ignored.
  logic              imemREN;
  logic [31:0]       imemaddr;
  logic              ihit;
  logic [31:0]       imemload;
  logic              deq;
  logic              valid_out;
  logic [31:0]       instr_out;
  logic [31:0]       npc_out;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              halt_in;
  logic              halt;
  logic [CNT_W-1:0]  count;

  modport master (
    output imemREN, imemaddr, valid_out, instr_out, npc_out, halt, count,
    input  ihit, imemload, deq, redirect, redirect_pc, halt_in
  );

  modport slave (
    input  imemREN, imemaddr, valid_out, instr_out, npc_out, halt, count,
    output ihit, imemload, deq, redirect, redirect_pc, halt_in
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, requests instruction words and
// buffers {instr, pc+4} in a DEPTH-entry FIFO ahead of decode.
module fetch_queue #(
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter int          DEPTH   = 4,
  parameter int          CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  fetch_queue_if.master fq
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      pc;
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      npc_mem   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             stop;
  logic             halt_r;

  logic             full;
  logic             push;
  logic             pop;
  logic [31:0]      pc_plus4;

  assign full     = (count == CNT_W'(DEPTH));
  assign pc_plus4 = pc + 32'd4;

  // Redirect kills the request in the same cycle so a stale word is never pushed.
  assign fq.imemREN  = ~halt_r & ~stop & ~fq.redirect & ~full;
  assign push        = fq.imemREN & fq.ihit;
  assign fq.valid_out = (count != '0) & ~halt_r;
  assign pop         = fq.deq & fq.valid_out & ~fq.redirect;

  assign fq.imemaddr  = pc;
  assign fq.instr_out = instr_mem[rd_ptr];
  assign fq.npc_out   = npc_mem[rd_ptr];
  assign fq.halt      = halt_r;
  assign fq.count     = count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc     <= PC_INIT;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      stop   <= 1'b0;
      halt_r <= 1'b0;
    end else begin
      if (fq.halt_in) halt_r <= 1'b1;
      // Once halted everything but halt itself is frozen, redirects included.
      if (!halt_r) begin
        if (fq.redirect) begin
          pc     <= fq.redirect_pc;
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
          stop   <= 1'b0;
        end else begin
          if (push) begin
            pc     <= pc_plus4;
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (fq.imemload[31:26] == 6'b111111) stop <= 1'b1;
          end
          if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
          if (push && !pop)      count <= count + CNT_W'(1);
          else if (pop && !push) count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Payload storage needs no reset; valid_out qualifies it.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem[wr_ptr] <= fq.imemload;
      npc_mem[wr_ptr]   <= pc_plus4;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic CLK;
  logic RST;
  fetch_queue_if #(.CNT_W(CNT_W)) fq ();

  fetch_queue #(.PC_INIT(32'h0), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .fq (fq.master)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model: entries are {instr, npc}
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  bit          m_stop;
  bit          m_halt;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit exp_valid();
    return (exp_q.size() != 0) && !m_halt;
  endfunction

  function automatic bit exp_ren();
    return !m_halt && !m_stop && !fq.redirect && (exp_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] norm_word();
    logic [31:0] r;
    r = $urandom();
    return {6'h08, r[25:0]};
  endfunction

  // driver: apply inputs for one cycle, advance the model across the edge
  task automatic cycle(input bit ih, input logic [31:0] ld, input bit dq,
                       input bit rd, input logic [31:0] rpc, input bit hi);
    bit ren, do_push, do_pop;
    fq.ihit = ih; fq.imemload = ld; fq.deq = dq;
    fq.redirect = rd; fq.redirect_pc = rpc; fq.halt_in = hi;
    ren     = !m_halt && !m_stop && !rd && (exp_q.size() < DEPTH);
    do_push = ren && ih;
    do_pop  = dq && (exp_q.size() != 0) && !m_halt;
    @(posedge CLK);
    if (RST) begin
      exp_q.delete(); m_pc = 32'h0; m_stop = 0; m_halt = 0;
    end else begin
      if (!m_halt) begin
        if (rd) begin
          exp_q.delete(); m_pc = rpc; m_stop = 0;
        end else begin
          if (do_pop) void'(exp_q.pop_front());
          if (do_push) begin
            exp_q.push_back({ld, m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
            if (ld[31:26] == 6'b111111) m_stop = 1;
          end
        end
      end
      if (hi) m_halt = 1;
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    cycle(0, 32'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (fq.imemaddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp %h", fq.imemaddr, 32'h0); end
    n_checks++; if (fq.count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fq.count); end
    n_checks++; if (fq.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", fq.valid_out); end
    n_checks++; if (fq.imemREN !== 1'b1) begin n_fail++; $display("FAIL reset_ren got %b exp 1", fq.imemREN); end
    n_checks++; if (fq.halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %b exp 0", fq.halt); end
  endtask

  task automatic test_fill();
    logic [31:0] w;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      n_checks++; if (fq.imemaddr !== m_pc) begin n_fail++; $display("FAIL fill_addr%0d got %h exp %h", k, fq.imemaddr, m_pc); end
      w = 32'h2000_0000 | (32'(k) << 16) | 32'(k);
      cycle(1, w, 0, 0, 32'h0, 0);
    end
    n_checks++; if (fq.count !== CNT_W'(4)) begin n_fail++; $display("FAIL fill_count got %0d exp 4", fq.count); end
    n_checks++; if (fq.imemREN !== 1'b0) begin n_fail++; $display("FAIL fill_ren got %b exp 0", fq.imemREN); end
    n_checks++; if (fq.imemaddr !== 32'h10) begin n_fail++; $display("FAIL fill_addr_hold got %h exp 10", fq.imemaddr); end
    n_checks++; if (fq.instr_out !== 32'h20010001) begin n_fail++; $display("FAIL fill_head got %h exp 20010001", fq.instr_out); end
    n_checks++; if (fq.npc_out !== 32'h4) begin n_fail++; $display("FAIL fill_npc got %h exp 4", fq.npc_out); end
  endtask

  task automatic test_deq_full();
    cycle(1, 32'h20050005, 1, 0, 32'h0, 0);
    n_checks++; if (fq.count !== CNT_W'(3)) begin n_fail++; $display("FAIL deqfull_count got %0d exp 3", fq.count); end
    n_checks++; if (fq.npc_out !== 32'h8) begin n_fail++; $display("FAIL deqfull_npc got %h exp 8", fq.npc_out); end
    n_checks++; if (fq.imemaddr !== 32'h10) begin n_fail++; $display("FAIL deqfull_addr got %h exp 10", fq.imemaddr); end
    cycle(1, 32'h20060006, 0, 0, 32'h0, 0);
    n_checks++; if (fq.count !== CNT_W'(4)) begin n_fail++; $display("FAIL deqfull_refill got %0d exp 4", fq.count); end
    n_checks++; if (fq.imemaddr !== 32'h14) begin n_fail++; $display("FAIL deqfull_addr2 got %h exp 14", fq.imemaddr); end
  endtask

  task automatic test_redirect();
    do_reset();
    cycle(1, norm_word(), 0, 0, 32'h0, 0);
    cycle(1, norm_word(), 0, 0, 32'h0, 0);
    fq.ihit = 1; fq.redirect = 1; fq.redirect_pc = 32'h40;
    #1;
    n_checks++; if (fq.imemREN !== 1'b0) begin n_fail++; $display("FAIL redir_ren_same got %b exp 0", fq.imemREN); end
    cycle(1, 32'h20aa0001, 1, 1, 32'h40, 0);
    fq.redirect = 0; fq.ihit = 0; fq.deq = 0;
    #1;
    n_checks++; if (fq.count !== CNT_W'(0)) begin n_fail++; $display("FAIL redir_count got %0d exp 0", fq.count); end
    n_checks++; if (fq.valid_out !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b exp 0", fq.valid_out); end
    n_checks++; if (fq.imemaddr !== 32'h40) begin n_fail++; $display("FAIL redir_addr got %h exp 40", fq.imemaddr); end
    n_checks++; if (fq.imemREN !== 1'b1) begin n_fail++; $display("FAIL redir_ren_next got %b exp 1", fq.imemREN); end
  endtask

  task automatic test_halt_opcode();
    do_reset();
    cycle(1, norm_word(), 0, 0, 32'h0, 0);
    cycle(1, norm_word(), 0, 0, 32'h0, 0);
    cycle(1, 32'hFC000000, 0, 0, 32'h0, 0);
    cycle(1, norm_word(), 0, 0, 32'h0, 0);
    n_checks++; if (fq.imemREN !== 1'b0) begin n_fail++; $display("FAIL hop_ren got %b exp 0", fq.imemREN); end
    n_checks++; if (fq.imemaddr !== 32'hC) begin n_fail++; $display("FAIL hop_addr got %h exp c", fq.imemaddr); end
    n_checks++; if (fq.count !== CNT_W'(3)) begin n_fail++; $display("FAIL hop_count got %0d exp 3", fq.count); end
    cycle(0, 32'h0, 1, 0, 32'h0, 0);
    cycle(0, 32'h0, 1, 0, 32'h0, 0);
    n_checks++; if (fq.instr_out !== 32'hFC000000) begin n_fail++; $display("FAIL hop_queued got %h exp fc000000", fq.instr_out); end
    cycle(0, 32'h0, 0, 1, 32'h100, 0);
    n_checks++; if (fq.imemaddr !== 32'h100) begin n_fail++; $display("FAIL hop_redir_addr got %h exp 100", fq.imemaddr); end
    cycle(1, 32'h20010001, 0, 0, 32'h0, 0);
    n_checks++; if (fq.count !== CNT_W'(1)) begin n_fail++; $display("FAIL hop_resume_count got %0d exp 1", fq.count); end
    n_checks++; if (fq.npc_out !== 32'h104) begin n_fail++; $display("FAIL hop_resume_npc got %h exp 104", fq.npc_out); end
  endtask

  task automatic test_halt();
    logic [31:0] addr_frozen;
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1, norm_word(), 0, 0, 32'h0, 0);
    cycle(1, norm_word(), 1, 0, 32'h0, 1);
    n_checks++; if (fq.halt !== 1'b1) begin n_fail++; $display("FAIL halt_set got %b exp 1", fq.halt); end
    n_checks++; if (fq.valid_out !== 1'b0) begin n_fail++; $display("FAIL halt_valid got %b exp 0", fq.valid_out); end
    n_checks++; if (fq.count !== CNT_W'(exp_q.size())) begin n_fail++; $display("FAIL halt_count got %0d exp %0d", fq.count, exp_q.size()); end
    addr_frozen = m_pc;
    cycle(1, norm_word(), 1, 1, 32'h200, 0);
    cycle(1, norm_word(), 1, 0, 32'h0, 0);
    n_checks++; if (fq.halt !== 1'b1) begin n_fail++; $display("FAIL halt_sticky got %b exp 1", fq.halt); end
    n_checks++; if (fq.count !== CNT_W'(3)) begin n_fail++; $display("FAIL halt_frozen_count got %0d exp 3", fq.count); end
    n_checks++; if (fq.imemaddr !== addr_frozen) begin n_fail++; $display("FAIL halt_frozen_addr got %h exp %h", fq.imemaddr, addr_frozen); end
    n_checks++; if (fq.imemREN !== 1'b0) begin n_fail++; $display("FAIL halt_ren got %b exp 0", fq.imemREN); end
    do_reset();
    n_checks++; if (fq.halt !== 1'b0) begin n_fail++; $display("FAIL halt_clear got %b exp 0", fq.halt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_npc;
    do_reset();
    cycle(1, norm_word(), 0, 0, 32'h0, 0);
    cycle(1, norm_word(), 0, 0, 32'h0, 0);
    prev_npc = 32'h4;
    for (int k = 0; k < 10; k++) begin
      cycle(1, norm_word(), 1, 0, 32'h0, 0);
      n_checks++; if (fq.count !== CNT_W'(2)) begin n_fail++; $display("FAIL b2b_count%0d got %0d exp 2", k, fq.count); end
      n_checks++; if (fq.npc_out !== prev_npc + 32'd4) begin n_fail++; $display("FAIL b2b_npc%0d got %h exp %h", k, fq.npc_out, prev_npc + 32'd4); end
      n_checks++; if (fq.instr_out !== exp_q[0][63:32]) begin n_fail++; $display("FAIL b2b_instr%0d got %h exp %h", k, fq.instr_out, exp_q[0][63:32]); end
      prev_npc = prev_npc + 32'd4;
    end
  endtask

  task automatic test_random();
    logic [31:0] ld, rpc, r;
    bit ih, dq, rd;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r   = $urandom();
      ih  = ($urandom_range(0, 3) != 0);
      dq  = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      ld  = ($urandom_range(0, 19) == 0) ? {6'b111111, r[25:0]} : norm_word();
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : {r[31:2], 2'b00};
      cycle(ih, ld, dq, rd, rpc, (k == 390));
      n_checks++; if (fq.imemaddr !== m_pc) begin n_fail++; $display("FAIL rnd_addr%0d got %h exp %h", k, fq.imemaddr, m_pc); end
      n_checks++; if (fq.count !== CNT_W'(exp_q.size())) begin n_fail++; $display("FAIL rnd_count%0d got %0d exp %0d", k, fq.count, exp_q.size()); end
      n_checks++; if (fq.valid_out !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid%0d got %b exp %b", k, fq.valid_out, exp_valid()); end
      n_checks++; if (fq.imemREN !== exp_ren()) begin n_fail++; $display("FAIL rnd_ren%0d got %b exp %b", k, fq.imemREN, exp_ren()); end
      n_checks++; if (fq.halt !== m_halt) begin n_fail++; $display("FAIL rnd_halt%0d got %b exp %b", k, fq.halt, m_halt); end
      if (exp_valid()) begin
        n_checks++; if ({fq.instr_out, fq.npc_out} !== exp_q[0]) begin n_fail++; $display("FAIL rnd_head%0d got %h exp %h", k, {fq.instr_out, fq.npc_out}, exp_q[0]); end
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    fq.ihit = 0; fq.imemload = '0; fq.deq = 0;
    fq.redirect = 0; fq.redirect_pc = '0; fq.halt_in = 0;
    exp_q.delete(); m_pc = 32'h0; m_stop = 0; m_halt = 0;
    @(negedge CLK);
    test_reset();
    test_fill();
    test_deq_full();
    test_redirect();
    test_halt_opcode();
    test_halt();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
